alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU (32-bit, 4-bit ctrl, zero flag) between two requesters.
//  - Round-robin arbitration, one operation in flight at a time.
//  - Operands and ctrl are registered and driven to the ALU; result and zero are captured back.
//  - Sits between the ALU and two clients, e.g. the main datapath and a multi-cycle mul/div helper.
// PARAMETERS
//  DATA_W  32  operand/result width
//  CTRL_W  4   ALU ctrl width (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR)
// PORTS
//  clk_i          in   1        clock, rising edge
//  rst_i          in   1        reset, synchronous, active-high
//  req_i          in   2        request per client; bit n = client n
//  src1_0_i       in   DATA_W   client 0 operand 1
//  src2_0_i       in   DATA_W   client 0 operand 2
//  ctrl_0_i       in   CTRL_W   client 0 ALU ctrl
//  src1_1_i       in   DATA_W   client 1 operand 1
//  src2_1_i       in   DATA_W   client 1 operand 2
//  ctrl_1_i       in   CTRL_W   client 1 ALU ctrl
//  gnt_o          out  2        one-hot pulse: operands of client n sampled this cycle
//  done_o         out  2        one-hot pulse: result_o/zero_o valid for client n
//  result_o       out  DATA_W   captured ALU result (shared bus)
//  zero_o         out  1        captured ALU zero flag
//  busy_o         out  1        1 whenever state != IDLE
//  alu_src1_o     out  DATA_W   registered operand 1 to ALU
//  alu_src2_o     out  DATA_W   registered operand 2 to ALU
//  alu_ctrl_o     out  CTRL_W   registered ctrl to ALU
//  alu_result_i   in   DATA_W   ALU result (combinational from alu_*_o)
//  alu_zero_i     in   1        ALU zero flag
// BEHAVIOUR
//  Reset (rst_i=1 at a clock edge) sets:
//   - state=IDLE, prio=0 (client 0 preferred)
//   - gnt_o=0, done_o=0, busy_o=0, result_o=0, zero_o=0, alu_*_o=0
//  FSM IDLE -> EXEC -> DONE -> IDLE:
//   - IDLE: if req_i!=0, pick the winner and register its src1/src2/ctrl into alu_*_o.
//     Assert gnt_o[winner] for this cycle only; next state EXEC. If req_i==0, stay in IDLE.
//   - EXEC: capture result_o<=alu_result_i and zero_o<=alu_zero_i at the end of the cycle; next DONE.
//   - DONE: done_o[owner]=1 for exactly this cycle; prio<=~owner; next IDLE.
//  Arbitration: one request wins. Both requesting -> winner = prio. prio always points to the
//   client not served last.
//  Latency: gnt cycle T, done_o at T+2; next gnt no earlier than T+3 (one op per 3 cycles max).
//  Handshake:
//   - Client holds req and operands stable until it sees gnt_o.
//   - Operands are ignored after gnt_o; the client may change them or drop req.
//   - A req still high in DONE is not granted until the following IDLE cycle.
//   - Dropping req before gnt withdraws the request, with no side effect.
//  Outputs:
//   - result_o/zero_o hold their last captured value until the next EXEC.
//   - alu_*_o hold their value until the next grant.
//  Arithmetic: the block does no arithmetic and passes values unchanged. Result width = DATA_W.
//   Unknown ctrl codes pass through; the ALU returns 0 for them.
//  Reset mid-operation (EXEC or DONE): the op is aborted, no done_o pulse, return to reset values.
//  gnt_o and done_o are never both nonzero in the same cycle. Each is at most one-hot.
// TESTING
//  1. Reset with req_i=2'b11 held -> gnt_o=0, done_o=0, result_o=0 during reset. First cycle after:
//     gnt_o=2'b01.
//  2. Client0 ADD 5+7 (ctrl 2), gnt at T -> alu_ctrl_o=2 at T+1. At T+2: done_o=2'b01,
//     result_o=12, zero_o=0.
//  3. Both request continuously: c0 SUB 9-9, c1 OR 0xF0|0x0F -> grants alternate 01,10,01 every
//     3 cycles. Results 0 (zero_o=1) and 0xFF.
//  4. Client1 alone SLT 3<8 (ctrl 7), then NOR 0|0 (ctrl 12) -> results 1 then 0xFFFFFFFF.
//     Second gnt exactly 3 cycles after the first.
//  5. rst_i=1 asserted in EXEC -> no done_o, busy_o=0 next cycle. A pending req is granted after reset.
//  6. req_i pulsed 1 cycle while busy, then dropped -> no grant. result_o unchanged.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two clients
// Ports:
//   clk_i, rst_i                   clock (rising edge), synchronous active-high reset
//   req_i[1:0]                     per-client request
//   src1_n_i, src2_n_i, ctrl_n_i   client n operands and ALU ctrl
//   gnt_o[1:0]                     one-hot: client operands sampled this cycle
//   done_o[1:0]                    one-hot: result_o/zero_o valid for that client
//   result_o, zero_o               captured ALU result and zero flag
//   busy_o                         high whenever an operation is in flight
//   alu_src1_o, alu_src2_o, alu_ctrl_o   registered operands to the ALU
//   alu_result_i, alu_zero_i       combinational ALU response
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [DATA_W-1:0] src1_0_i,
    input  logic [DATA_W-1:0] src2_0_i,
    input  logic [CTRL_W-1:0] ctrl_0_i,
    input  logic [DATA_W-1:0] src1_1_i,
    input  logic [DATA_W-1:0] src2_1_i,
    input  logic [CTRL_W-1:0] ctrl_1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state;
    logic   prio;
    logic   owner;
    logic   win;
    // The grant must name the cycle the operands are sampled, so it is decoded
    // from the registered state rather than registered itself.
    always_comb begin
        win   = (req_i == 2'b11) ? prio : req_i[1];
        gnt_o = (state == IDLE && !rst_i && req_i != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
    end
    assign busy_o = (state != IDLE);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            done_o     <= 2'b00;
            result_o   <= '0;
            zero_o     <= 1'b0;
            alu_src1_o <= '0;
            alu_src2_o <= '0;
            alu_ctrl_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 2'b00;
                    if (req_i != 2'b00) begin
                        owner      <= win;
                        alu_src1_o <= win ? src1_1_i : src1_0_i;
                        alu_src2_o <= win ? src2_1_i : src2_0_i;
                        alu_ctrl_o <= win ? ctrl_1_i : ctrl_0_i;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result_o <= alu_result_i;
                    zero_o   <= alu_zero_i;
                    done_o   <= owner ? 2'b10 : 2'b01;
                    state    <= DONE;
                end
                DONE: begin
                    done_o <= 2'b00;
                    prio   <= ~owner;
                    state  <= IDLE;
                end
                default: begin
                    done_o <= 2'b00;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for the shared-ALU arbiter
module tb_alu_share_arbiter;
    localparam int DW = 32;
    localparam int CW = 4;
    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [1:0]    req_i;
    logic [DW-1:0] src1_0_i, src2_0_i, src1_1_i, src2_1_i;
    logic [CW-1:0] ctrl_0_i, ctrl_1_i;
    logic [1:0]    gnt_o, done_o;
    logic [DW-1:0] result_o, alu_src1_o, alu_src2_o, alu_result_i;
    logic [CW-1:0] alu_ctrl_o;
    logic          zero_o, busy_o, alu_zero_i;

    alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
        .src1_0_i(src1_0_i), .src2_0_i(src2_0_i), .ctrl_0_i(ctrl_0_i),
        .src1_1_i(src1_1_i), .src2_1_i(src2_1_i), .ctrl_1_i(ctrl_1_i),
        .gnt_o(gnt_o), .done_o(done_o), .result_o(result_o), .zero_o(zero_o), .busy_o(busy_o),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        case (alu_ctrl_o)
            4'd0:    alu_result_i = alu_src1_o & alu_src2_o;
            4'd1:    alu_result_i = alu_src1_o | alu_src2_o;
            4'd2:    alu_result_i = alu_src1_o + alu_src2_o;
            4'd6:    alu_result_i = alu_src1_o - alu_src2_o;
            4'd7:    alu_result_i = {31'd0, $signed(alu_src1_o) < $signed(alu_src2_o)};
            4'd12:   alu_result_i = ~(alu_src1_o | alu_src2_o);
            default: alu_result_i = '0;
        endcase
        alu_zero_i = (alu_result_i == '0);
    end

    typedef struct {
        logic [1:0]  d;
        logic [31:0] r;
        logic        z;
    } exp_t;
    exp_t       dq[$];
    logic [1:0] gq[$];
    int         gtimes[$];
    int         cyc = 0;
    int         last_g = -100;
    int         checks = 0;
    int         failures = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        src1_0_i = a; src2_0_i = b; ctrl_0_i = c;
    endtask

    task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        src1_1_i = a; src2_1_i = b; ctrl_1_i = c;
    endtask

    task automatic expect_op(input logic [1:0] g, input logic [31:0] r, input logic z);
        exp_t e;
        e.d = g; e.r = r; e.z = z;
        gq.push_back(g);
        dq.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant or a done.
    always @(negedge clk_i) begin
        if (gnt_o != 2'b00 || done_o != 2'b00)
            chk("gnt_done_overlap", {62'd0, (gnt_o != 2'b00) && (done_o != 2'b00)}, 64'd0);
        if (gnt_o != 2'b00) begin
            if (gq.size() == 0) chk("unexpected_gnt", {62'd0, gnt_o}, 64'd0);
            else chk("gnt", {62'd0, gnt_o}, {62'd0, gq.pop_front()});
            last_g = cyc;
            gtimes.push_back(cyc);
        end
        if (done_o != 2'b00) begin
            chk("done_latency", 64'(cyc), 64'(last_g + 2));
            if (dq.size() == 0) chk("unexpected_done", {62'd0, done_o}, 64'd0);
            else begin
                exp_t e;
                e = dq.pop_front();
                chk("done_owner", {62'd0, done_o}, {62'd0, e.d});
                chk("result", {32'd0, result_o}, {32'd0, e.r});
                chk("zero", {63'd0, zero_o}, {63'd0, e.z});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both clients requesting
        rst_i = 1'b1;
        req_i = 2'b11;
        set0(32'd5, 32'd7, 4'd2);
        set1(32'hF0, 32'h0F, 4'd1);
        cycles(2);
        @(negedge clk_i);
        chk("rst_gnt", {62'd0, gnt_o}, 64'd0);
        chk("rst_done", {62'd0, done_o}, 64'd0);
        chk("rst_result", {32'd0, result_o}, 64'd0);
        chk("rst_zero", {63'd0, zero_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_alu_ctrl", {60'd0, alu_ctrl_o}, 64'd0);
        chk("rst_alu_src1", {32'd0, alu_src1_o}, 64'd0);
        expect_op(2'b01, 32'd12, 1'b0);
        expect_op(2'b10, 32'hFF, 1'b0);
        cycles(1);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("t1_first_gnt", {62'd0, gnt_o}, 64'h1);
        cycles(1);
        req_i = 2'b10;
        @(negedge clk_i);
        chk("t2_alu_ctrl", {60'd0, alu_ctrl_o}, 64'd2);
        chk("t2_alu_src1", {32'd0, alu_src1_o}, 64'd5);
        chk("t2_alu_src2", {32'd0, alu_src2_o}, 64'd7);
        chk("t2_busy", {63'd0, busy_o}, 64'd1);
        cycles(1);
        @(negedge clk_i);
        chk("t2_result", {32'd0, result_o}, 64'd12);
        cycles(2);
        req_i = 2'b00;
        cycles(2);
        // Both clients requesting continuously: grants alternate
        set0(32'd9, 32'd9, 4'd6);
        set1(32'hF0, 32'h0F, 4'd1);
        req_i = 2'b11;
        expect_op(2'b01, 32'd0, 1'b1);
        expect_op(2'b10, 32'hFF, 1'b0);
        expect_op(2'b01, 32'd0, 1'b1);
        cycles(7);
        req_i = 2'b00;
        cycles(2);
        // Client 1 alone: SLT then NOR, operands changed right after the first grant
        set1(32'd3, 32'd8, 4'd7);
        req_i = 2'b10;
        expect_op(2'b10, 32'd1, 1'b0);
        expect_op(2'b10, 32'hFFFF_FFFF, 1'b0);
        cycles(1);
        set1(32'd0, 32'd0, 4'd12);
        cycles(3);
        req_i = 2'b00;
        cycles(2);
        // Reset during EXEC aborts the op; a pending request is granted afterwards
        set0(32'hFF, 32'h0F, 4'd0);
        req_i = 2'b01;
        gq.push_back(2'b01);
        cycles(1);
        rst_i = 1'b1;
        req_i = 2'b10;
        set1(32'd1, 32'd1, 4'd2);
        cycles(1);
        rst_i = 1'b0;
        expect_op(2'b10, 32'd2, 1'b0);
        @(negedge clk_i);
        chk("t5_busy_after_rst", {63'd0, busy_o}, 64'd0);
        chk("t5_result_after_rst", {32'd0, result_o}, 64'd0);
        cycles(1);
        req_i = 2'b00;
        cycles(3);
        // A request pulsed only while busy is never granted
        set0(32'd10, 32'd3, 4'd6);
        req_i = 2'b01;
        expect_op(2'b01, 32'd7, 1'b0);
        cycles(1);
        req_i = 2'b10;
        set1(32'd5, 32'd5, 4'd2);
        cycles(1);
        req_i = 2'b00;
        cycles(2);
        @(negedge clk_i);
        chk("t6_result_held", {32'd0, result_o}, 64'd7);
        chk("t6_busy", {63'd0, busy_o}, 64'd0);
        chk("t6_alu_ctrl_held", {60'd0, alu_ctrl_o}, 64'd6);
        cycles(2);
        chk("gnt_count", 64'(gtimes.size()), 64'd10);
        if (gtimes.size() == 10) begin
            chk("t2_gnt_spacing", 64'(gtimes[1] - gtimes[0]), 64'd3);
            chk("t3_gnt_spacing_a", 64'(gtimes[3] - gtimes[2]), 64'd3);
            chk("t3_gnt_spacing_b", 64'(gtimes[4] - gtimes[3]), 64'd3);
            chk("t4_gnt_spacing", 64'(gtimes[6] - gtimes[5]), 64'd3);
            chk("t5_regrant", 64'(gtimes[8] - gtimes[7]), 64'd2);
        end
        chk("gq_empty", 64'(gq.size()), 64'd0);
        chk("dq_empty", 64'(dq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
